// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial sequencer driving an external 1-bit full adder, LSB first
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin_init,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_c
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb, res_sh, res_nx;
    logic             carry;
    logic [CW-1:0]    count;

    // Incoming sum bit enters at the MSB so the LSB-first stream lands in place.
    generate
        if (WIDTH == 1) begin : g_one
            assign res_nx = fa_sum;
        end else begin : g_multi
            assign res_nx = {fa_sum, res_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        fa_a     = 1'b0;
        fa_b     = 1'b0;
        fa_cin   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = SHIFT;
            end
            SHIFT: begin
                busy   = 1'b1;
                fa_a   = sa[0];
                fa_b   = sb[0];
                fa_cin = carry;
                if (count == LAST) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            count  <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= op_a;
                        sb    <= op_b;
                        carry <= cin_init;
                        count <= '0;
                    end
                end
                SHIFT: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    res_sh <= res_nx;
                    carry  <= fa_c;
                    count  <= count + CW'(1);
                    // result/cout only move here, so they hold through the next operation.
                    if (count == LAST) begin
                        result <= res_nx;
                        cout   <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl (WIDTH=4 and WIDTH=1)
module tb_serial_add_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic         cin_init;
    logic         busy, done, cout;
    logic [W-1:0] result;
    logic         fa_a, fa_b, fa_cin, fa_sum, fa_c;

    logic start1, a1, b1, ci1;
    logic busy1, done1, res1, cout1;
    logic fa1_a, fa1_b, fa1_cin, fa1_sum, fa1_c;

    int n_tests = 0;
    int n_fail  = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .cin_init(cin_init), .busy(busy), .done(done), .result(result),
        .cout(cout), .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
        .fa_sum(fa_sum), .fa_c(fa_c)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op_a(a1), .op_b(b1),
        .cin_init(ci1), .busy(busy1), .done(done1), .result(res1),
        .cout(cout1), .fa_a(fa1_a), .fa_b(fa1_b), .fa_cin(fa1_cin),
        .fa_sum(fa1_sum), .fa_c(fa1_c)
    );

    // External full-adder cells
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_c    = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
    assign fa1_sum = fa1_a ^ fa1_b ^ fa1_cin;
    assign fa1_c   = (fa1_a & fa1_b) | (fa1_a & fa1_cin) | (fa1_b & fa1_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] exp_res;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Carry entering bit i is the overflow of adding the low i bits.
    function automatic int carry_into(input int a, input int b, input int ci, input int i);
        int m;
        m = 1 << i;
        return (((a % m) + (b % m) + ci) >> i) & 1;
    endfunction

    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic [W:0] exp_sum, input string tag);
        logic [W-1:0] prev_r;
        logic         prev_c;
        int           nb;
        bit           seen, fa_ok, hold_ok;
        @(negedge clk);
        prev_r = result; prev_c = cout;
        start = 1'b1; op_a = a; op_b = b; cin_init = ci;
        @(negedge clk);
        start = 1'b0; op_a = W'($urandom); op_b = W'($urandom); cin_init = 1'($urandom);
        nb = 0; seen = 0; fa_ok = 1; hold_ok = 1;
        for (int k = 0; k < W + 4; k++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) begin
                if (nb >= W) fa_ok = 0;
                else if (fa_a != a[nb] || fa_b != b[nb] ||
                         int'(fa_cin) != carry_into(int'(a), int'(b), int'(ci), nb)) fa_ok = 0;
                if (result != prev_r || cout != prev_c) hold_ok = 0;
                nb++;
            end
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, int'(seen), 1);
        chk({tag, "_busy_cycles"}, nb, W);
        chk({tag, "_fa_stream"}, int'(fa_ok), 1);
        chk({tag, "_hold"}, int'(hold_ok), 1);
        chk({tag, "_result"}, int'(result), int'(exp_sum[W-1:0]));
        chk({tag, "_cout"}, int'(cout), int'(exp_sum[W]));
        @(negedge clk);
        chk({tag, "_done_pulse"}, int'(done), 0);
        chk({tag, "_idle_after"}, int'(busy), 0);
    endtask

    task automatic do_add1(input logic a, input logic b, input logic ci);
        int  nb;
        bit  seen;
        int  s;
        s = int'(a) + int'(b) + int'(ci);
        @(negedge clk);
        start1 = 1'b1; a1 = a; b1 = b; ci1 = ci;
        @(negedge clk);
        start1 = 1'b0;
        nb = 0; seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (done1) begin
                seen = 1;
                break;
            end
            if (busy1) nb++;
            @(negedge clk);
        end
        chk("w1_done_seen", int'(seen), 1);
        chk("w1_busy_cycles", nb, 1);
        chk("w1_result", int'(res1), s & 1);
        chk("w1_cout", int'(cout1), s >> 1);
    endtask

    initial begin
        int  k;
        int  ndone;
        logic [W-1:0] ra, rb;
        logic         rc;

        vecs[0] = '{4'd5,  4'd3,  1'b0, 4'd8,  1'b0};
        vecs[1] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1};
        vecs[2] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
        vecs[3] = '{4'd9,  4'd6,  1'b0, 4'd15, 1'b0};
        vecs[4] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0};
        vecs[5] = '{4'd0,  4'd0,  1'b1, 4'd1,  1'b0};
        vecs[6] = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1};
        vecs[7] = '{4'd10, 4'd5,  1'b1, 4'd0,  1'b1};
        vecs[8] = '{4'd6,  4'd7,  1'b1, 4'd14, 1'b0};

        rst = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin_init = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;

        // Reset with no clock edge yet
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_cout", int'(cout), 0);
        chk("rst_fa", int'({fa_a, fa_b, fa_cin}), 0);
        chk("rst_w1", int'({busy1, done1, res1, cout1}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i])
            do_add(vecs[i].a, vecs[i].b, vecs[i].ci, {vecs[i].exp_cout, vecs[i].exp_res},
                   $sformatf("vec%0d", i));

        // start held high and operands changed mid-operation
        @(negedge clk);
        start = 1'b1; op_a = 4'd9; op_b = 4'd6; cin_init = 1'b0;
        @(negedge clk);
        op_a = 4'd0; op_b = 4'd0;
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("hs_done", int'(done), 1);
        chk("hs_latency", k, W);
        chk("hs_result", int'(result), 15);
        chk("hs_cout", int'(cout), 0);
        @(negedge clk);
        chk("hs_gap_idle", int'(busy), 0);
        @(negedge clk);
        chk("hs_restart", int'(busy), 1);
        start = 1'b0;
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("hs2_done", int'(done), 1);
        chk("hs2_result", int'(result), 0);
        chk("hs2_cout", int'(cout), 0);

        // Reset in the middle of an operation
        do_add(4'd15, 4'd15, 1'b1, 5'd31, "pre_rst");
        @(negedge clk);
        start = 1'b1; op_a = 4'd7; op_b = 4'd7; cin_init = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_result", int'(result), 0);
        chk("mid_rst_cout", int'(cout), 0);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("mid_rst_no_done", ndone, 0);
        do_add(4'd2, 4'd2, 1'b0, 5'd4, "post_rst");

        // Randomized operands against plain-arithmetic reference
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            rc = 1'($urandom);
            do_add(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {4'd0, rc}, $sformatf("rand%0d", i));
        end

        // WIDTH=1 instance, exhaustive
        for (int i = 0; i < 8; i++)
            do_add1(i[2], i[1], i[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
